cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Merges two result streams (ALU and load unit) onto a single common data
//   bus. Each source feeds its own small FIFO; one head per cycle is popped
//   onto registered CDB outputs using 1-bit round-robin arbitration.
//
// Ports
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset
//   rdy_in        global enable; low freezes all state and outputs
//   clear_in      mispredict flush; empties both queues, kills the broadcast
//   alu_valid     ALU result present this cycle
//   alu_value     ALU result value
//   alu_rob_id    ALU destination ROB tag
//   mem_valid     load result present this cycle
//   mem_value     load result value
//   mem_rob_id    load destination ROB tag
//   alu_full      ALU queue almost full (combinational)
//   mem_full      MEM queue almost full (combinational)
//   cdb_valid     registered broadcast valid
//   cdb_value     registered broadcast value
//   cdb_rob_id    registered broadcast tag
//   err_overflow  sticky flag: a write to a full, non-popped queue was dropped

module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 alu_valid,
    input  logic [31:0]          alu_value,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_value,
    input  logic [ROB_WIDTH-1:0] mem_rob_id,
    output logic                 alu_full,
    output logic                 mem_full,
    output logic                 cdb_valid,
    output logic [31:0]          cdb_value,
    output logic [ROB_WIDTH-1:0] cdb_rob_id,
    output logic                 err_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR    = PTR_W'(1);

    // Source encoding used by last_grant
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic [31:0]          alu_val_q [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0] alu_tag_q [FIFO_DEPTH];
    logic [31:0]          mem_val_q [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0] mem_tag_q [FIFO_DEPTH];

    logic [PTR_W-1:0] alu_head, alu_tail, mem_head, mem_tail;
    logic [CNT_W-1:0] alu_count, mem_count;
    logic             last_grant;

    logic active;
    logic alu_nonempty, mem_nonempty;
    logic grant_alu, grant_mem;
    logic alu_push, mem_push;
    logic alu_drop, mem_drop;

    // Arbitration only looks at registered queue state, so a result entering
    // a queue this cycle can reach the CDB no earlier than two edges later.
    assign active       = rdy_in && !clear_in;
    assign alu_nonempty = (alu_count != '0);
    assign mem_nonempty = (mem_count != '0);
    assign grant_alu    = active && alu_nonempty && (!mem_nonempty || last_grant == SRC_MEM);
    assign grant_mem    = active && mem_nonempty && (!alu_nonempty || last_grant == SRC_ALU);

    // A full queue can still accept a write when its head leaves at the same edge.
    assign alu_push = active && alu_valid && ((alu_count != DEPTH_CNT) || grant_alu);
    assign mem_push = active && mem_valid && ((mem_count != DEPTH_CNT) || grant_mem);
    assign alu_drop = active && alu_valid && (alu_count == DEPTH_CNT) && !grant_alu;
    assign mem_drop = active && mem_valid && (mem_count == DEPTH_CNT) && !grant_mem;

    assign alu_full = (alu_count >= ALMOST_CNT);
    assign mem_full = (mem_count >= ALMOST_CNT);

    // Queue storage carries no reset: only the pointers and counts decide
    // which slots hold live entries.
    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_val_q[alu_tail] <= alu_value;
            alu_tag_q[alu_tail] <= alu_rob_id;
        end
        if (mem_push) begin
            mem_val_q[mem_tail] <= mem_value;
            mem_tag_q[mem_tail] <= mem_rob_id;
        end
    end

    // Pointers, counts, CDB registers and flags. Reset wins over everything;
    // with rdy_in low nothing changes; a flush empties the queues but keeps
    // the arbitration history and the overflow flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            alu_head     <= '0;
            alu_tail     <= '0;
            alu_count    <= '0;
            mem_head     <= '0;
            mem_tail     <= '0;
            mem_count    <= '0;
            last_grant   <= SRC_MEM;
            cdb_valid    <= 1'b0;
            cdb_value    <= '0;
            cdb_rob_id   <= '0;
            err_overflow <= 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                alu_head  <= '0;
                alu_tail  <= '0;
                alu_count <= '0;
                mem_head  <= '0;
                mem_tail  <= '0;
                mem_count <= '0;
                cdb_valid <= 1'b0;
            end else begin
                if (alu_push) alu_tail <= alu_tail + ONE_PTR;
                if (grant_alu) alu_head <= alu_head + ONE_PTR;
                if (mem_push) mem_tail <= mem_tail + ONE_PTR;
                if (grant_mem) mem_head <= mem_head + ONE_PTR;

                case ({alu_push, grant_alu})
                    2'b10:   alu_count <= alu_count + ONE_CNT;
                    2'b01:   alu_count <= alu_count - ONE_CNT;
                    default: alu_count <= alu_count;
                endcase

                case ({mem_push, grant_mem})
                    2'b10:   mem_count <= mem_count + ONE_CNT;
                    2'b01:   mem_count <= mem_count - ONE_CNT;
                    default: mem_count <= mem_count;
                endcase

                // Value and tag only move on a grant so they hold while idle
                if (grant_alu) begin
                    cdb_valid  <= 1'b1;
                    cdb_value  <= alu_val_q[alu_head];
                    cdb_rob_id <= alu_tag_q[alu_head];
                    last_grant <= SRC_ALU;
                end else if (grant_mem) begin
                    cdb_valid  <= 1'b1;
                    cdb_value  <= mem_val_q[mem_head];
                    cdb_rob_id <= mem_tag_q[mem_head];
                    last_grant <= SRC_MEM;
                end else begin
                    cdb_valid <= 1'b0;
                end

                if (alu_drop || mem_drop) err_overflow <= 1'b1;
            end
        end
    end

endmodule
